// File: rtl/morse_encoder.sv
// -----------------------------------------------------------------------------
// morse_encoder
//
// Accepts one ASCII byte at a time over a valid/ready handshake and keys
// morse_out with standard Morse unit timing. Only one character is in flight
// at a time, and there is no input queue.
//
// Parameters
//   FINAL_VALUE : clock cycles per Morse unit (>= 2)
//
// Ports
//   clk        in   system clock; all logic on the rising edge
//   reset      in   synchronous, active-high; returns the block to IDLE
//   din        in   [7:0] ASCII character to send
//   din_valid  in   din is presented this cycle
//   ready      out  block can accept a character this cycle
//   morse_out  out  key line, 1 = mark (tone / LED on)
//   busy       out  a character or gap is being sent (~ready)
//   char_done  out  one-cycle pulse when a trailing gap has finished
//   err        out  one-cycle pulse when an accepted byte is unsupported
// -----------------------------------------------------------------------------
module morse_encoder #(
    parameter int FINAL_VALUE = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       ready,
    output logic       morse_out,
    output logic       busy,
    output logic       char_done,
    output logic       err
);

    localparam int            CW       = $clog2(FINAL_VALUE);
    localparam logic [CW-1:0] CYC_LAST = CW'(FINAL_VALUE - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MARK = 3'd1;
    localparam logic [2:0] S_SGAP = 3'd2;
    localparam logic [2:0] S_LGAP = 3'd3;
    localparam logic [2:0] S_WGAP = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] cyc;
    logic [2:0]    units;
    logic [2:0]    idx;
    logic [4:0]    pat_r;

    logic [7:0]    upper;
    logic [7:0]    tbl;
    logic [2:0]    tbl_len;
    logic [4:0]    tbl_pat;
    logic          is_space;

    logic          accept;
    logic          tick;
    logic [2:0]    need;
    logic          state_done;
    logic          load;
    logic          err_nxt;
    logic          done_nxt;

    // -------------------------------------------------------------------------
    // Morse table: {len[2:0], pat[4:0]}; pat[len-1] is the first symbol,
    // 1 = dash. len == 0 marks the byte unsupported.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        upper = din;
        if (din >= 8'h61 && din <= 8'h7A) begin
            upper = din - 8'h20;
        end
        tbl = 8'h00;
        case (upper)
            8'h41: tbl = {3'd2, 5'b00001}; // A .-
            8'h42: tbl = {3'd4, 5'b01000}; // B -...
            8'h43: tbl = {3'd4, 5'b01010}; // C -.-.
            8'h44: tbl = {3'd3, 5'b00100}; // D -..
            8'h45: tbl = {3'd1, 5'b00000}; // E .
            8'h46: tbl = {3'd4, 5'b00010}; // F ..-.
            8'h47: tbl = {3'd3, 5'b00110}; // G --.
            8'h48: tbl = {3'd4, 5'b00000}; // H ....
            8'h49: tbl = {3'd2, 5'b00000}; // I ..
            8'h4A: tbl = {3'd4, 5'b00111}; // J .---
            8'h4B: tbl = {3'd3, 5'b00101}; // K -.-
            8'h4C: tbl = {3'd4, 5'b00100}; // L .-..
            8'h4D: tbl = {3'd2, 5'b00011}; // M --
            8'h4E: tbl = {3'd2, 5'b00010}; // N -.
            8'h4F: tbl = {3'd3, 5'b00111}; // O ---
            8'h50: tbl = {3'd4, 5'b00110}; // P .--.
            8'h51: tbl = {3'd4, 5'b01101}; // Q --.-
            8'h52: tbl = {3'd3, 5'b00010}; // R .-.
            8'h53: tbl = {3'd3, 5'b00000}; // S ...
            8'h54: tbl = {3'd1, 5'b00001}; // T -
            8'h55: tbl = {3'd3, 5'b00001}; // U ..-
            8'h56: tbl = {3'd4, 5'b00001}; // V ...-
            8'h57: tbl = {3'd3, 5'b00011}; // W .--
            8'h58: tbl = {3'd4, 5'b01001}; // X -..-
            8'h59: tbl = {3'd4, 5'b01011}; // Y -.--
            8'h5A: tbl = {3'd4, 5'b01100}; // Z --..
            8'h30: tbl = {3'd5, 5'b11111}; // 0 -----
            8'h31: tbl = {3'd5, 5'b01111}; // 1 .----
            8'h32: tbl = {3'd5, 5'b00111}; // 2 ..---
            8'h33: tbl = {3'd5, 5'b00011}; // 3 ...--
            8'h34: tbl = {3'd5, 5'b00001}; // 4 ....-
            8'h35: tbl = {3'd5, 5'b00000}; // 5 .....
            8'h36: tbl = {3'd5, 5'b10000}; // 6 -....
            8'h37: tbl = {3'd5, 5'b11000}; // 7 --...
            8'h38: tbl = {3'd5, 5'b11100}; // 8 ---..
            8'h39: tbl = {3'd5, 5'b11110}; // 9 ----.
            default: tbl = 8'h00;
        endcase
    end

    assign tbl_len  = tbl[7:5];
    assign tbl_pat  = tbl[4:0];
    assign is_space = (din == 8'h20);

    // -------------------------------------------------------------------------
    // Timing: a unit tick every FINAL_VALUE cycles; a state ends on the tick
    // that completes its required number of units.
    // -------------------------------------------------------------------------
    assign accept = din_valid & ready;
    assign tick   = (cyc == CYC_LAST);

    always_comb begin
        case (state)
            S_MARK:  need = pat_r[idx] ? 3'd3 : 3'd1;
            S_SGAP:  need = 3'd1;
            S_LGAP:  need = 3'd3;
            S_WGAP:  need = 3'd4;
            default: need = 3'd1;
        endcase
    end

    assign state_done = (state != S_IDLE) && tick && (units == need - 3'd1);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        err_nxt   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_space) begin
                        state_nxt = S_WGAP;
                    end else if (tbl_len != 3'd0) begin
                        state_nxt = S_MARK;
                        load      = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_MARK: begin
                if (state_done) begin
                    state_nxt = (idx == 3'd0) ? S_LGAP : S_SGAP;
                end
            end
            S_SGAP: begin
                if (state_done) begin
                    state_nxt = S_MARK;
                end
            end
            S_LGAP, S_WGAP: begin
                if (state_done) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State, counters and registered outputs. Outputs are decoded from the
    // next state so they change on the same edge as the state register.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state     <= S_IDLE;
            cyc       <= '0;
            units     <= 3'd0;
            idx       <= 3'd0;
            pat_r     <= 5'd0;
            ready     <= 1'b1;
            morse_out <= 1'b0;
            char_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            ready     <= (state_nxt == S_IDLE);
            morse_out <= (state_nxt == S_MARK);
            char_done <= done_nxt;
            err       <= err_nxt;

            if (load) begin
                pat_r <= tbl_pat;
                idx   <= tbl_len - 3'd1;
            end else if (state == S_MARK && state_done && idx != 3'd0) begin
                idx <= idx - 3'd1;
            end

            // Counters restart on every state entry and stay parked in IDLE.
            if (state_nxt != state || state == S_IDLE) begin
                cyc   <= '0;
                units <= 3'd0;
            end else if (tick) begin
                cyc   <= '0;
                units <= units + 3'd1;
            end else begin
                cyc <= cyc + 1'b1;
            end
        end
    end

    assign busy = ~ready;

endmodule

// File: tb/tb_morse_encoder.sv
// -----------------------------------------------------------------------------
// tb_morse_encoder
//
// Self-checking bench for morse_encoder with FINAL_VALUE = 4. A reference
// model builds the expected per-cycle key waveform from dot/dash strings and
// the unit rules; every cycle of every character is compared.
// -----------------------------------------------------------------------------
module tb_morse_encoder;

    localparam int FV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;
    logic       ready;
    logic       morse_out;
    logic       busy;
    logic       char_done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    morse_encoder #(.FINAL_VALUE(FV)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .ready     (ready),
        .morse_out (morse_out),
        .busy      (busy),
        .char_done (char_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic observed, input logic expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Reference Morse table as dot/dash text; "" means unsupported.
    function automatic string morse_of(input logic [7:0] c);
        logic [7:0] u;
        u = c;
        if (c >= "a" && c <= "z") u = c - 8'd32;
        case (u)
            "A": return ".-";    "B": return "-...";  "C": return "-.-.";
            "D": return "-..";   "E": return ".";     "F": return "..-.";
            "G": return "--.";   "H": return "....";  "I": return "..";
            "J": return ".---";  "K": return "-.-";   "L": return ".-..";
            "M": return "--";    "N": return "-.";    "O": return "---";
            "P": return ".--.";  "Q": return "--.-";  "R": return ".-.";
            "S": return "...";   "T": return "-";     "U": return "..-";
            "V": return "...-";  "W": return ".--";   "X": return "-..-";
            "Y": return "-.--";  "Z": return "--..";
            "0": return "-----"; "1": return ".----"; "2": return "..---";
            "3": return "...--"; "4": return "....-"; "5": return ".....";
            "6": return "-...."; "7": return "--..."; "8": return "---..";
            "9": return "----.";
            default: return "";
        endcase
    endfunction

    // Sends one byte (DUT must be ready) and checks every cycle until the
    // first cycle in which the DUT is ready again. Returns at that cycle's
    // falling edge so the caller may present the next byte back-to-back.
    task automatic send(input logic [7:0] c, input bit noise);
        string m;
        bit    wave[$];
        bit    supported;
        int    n;
        m = morse_of(c);
        supported = (c == 8'h20) || (m.len() != 0);
        if (c == 8'h20) begin
            for (int k = 0; k < 4 * FV; k++) wave.push_back(1'b0);
        end else if (m.len() != 0) begin
            for (int j = 0; j < m.len(); j++) begin
                for (int k = 0; k < ((m[j] == "-") ? 3 : 1) * FV; k++) wave.push_back(1'b1);
                if (j < m.len() - 1)
                    for (int k = 0; k < FV; k++) wave.push_back(1'b0);
            end
            for (int k = 0; k < 3 * FV; k++) wave.push_back(1'b0);
        end
        n = wave.size();

        check($sformatf("ready_before_%h", c), ready, 1'b1);
        din       = c;
        din_valid = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= n + 1; i++) begin
            @(negedge clk);
            if (i <= n) begin
                check($sformatf("morse_%h@%0d", c, i), morse_out, wave[i-1]);
                check($sformatf("ready_%h@%0d", c, i), ready, 1'b0);
                check($sformatf("busy_%h@%0d", c, i), busy, 1'b1);
                check($sformatf("done_%h@%0d", c, i), char_done, 1'b0);
                check($sformatf("err_%h@%0d", c, i), err, 1'b0);
            end else begin
                check($sformatf("morse_end_%h", c), morse_out, 1'b0);
                check($sformatf("ready_end_%h", c), ready, 1'b1);
                check($sformatf("busy_end_%h", c), busy, 1'b0);
                check($sformatf("done_end_%h", c), char_done, supported);
                check($sformatf("err_end_%h", c), err, !supported);
            end
            if (i <= n && noise) begin
                din_valid = 1'($urandom_range(0, 1));
                din       = 8'($urandom);
            end else begin
                din_valid = 1'b0;
            end
        end
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            check("idle_ready", ready, 1'b1);
            check("idle_morse", morse_out, 1'b0);
            check("idle_done", char_done, 1'b0);
            check("idle_err", err, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c;
        int         r;
        reset     = 1'b1;
        din       = 8'h00;
        din_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_morse", morse_out, 1'b0);
        check("rst_ready", ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", char_done, 1'b0);
        check("rst_err", err, 1'b0);
        reset = 1'b0;
        idle_cycles(2);

        // Directed scenarios
        send("E", 1'b0);
        idle_cycles(2);
        send("A", 1'b0);
        send("T", 1'b0);          // accepted in A's char_done cycle
        idle_cycles(1);
        send("0", 1'b0);
        send("e", 1'b0);
        idle_cycles(1);
        send("E", 1'b0);
        send(8'h20, 1'b0);        // word gap
        send("E", 1'b0);
        send("#", 1'b0);          // unsupported: err pulse only
        send("T", 1'b0);          // accepted the very next cycle
        idle_cycles(1);

        // Reset mid-dash with din_valid held high during the mark
        din       = "T";
        din_valid = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("dash_morse", morse_out, 1'b1);
            check("dash_ready", ready, 1'b0);
            din       = "E";
            din_valid = 1'b1;
        end
        reset     = 1'b1;
        din_valid = 1'b0;
        @(negedge clk);
        check("midrst_morse", morse_out, 1'b0);
        check("midrst_ready", ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", char_done, 1'b0);
        check("midrst_err", err, 1'b0);
        reset = 1'b0;
        idle_cycles(20);
        send("E", 1'b0);

        // Randomized traffic with ignored din_valid noise while busy
        for (int t = 0; t < 30; t++) begin
            r = $urandom_range(0, 4);
            case (r)
                0:       c = 8'("A" + $urandom_range(0, 25));
                1:       c = 8'("a" + $urandom_range(0, 25));
                2:       c = 8'("0" + $urandom_range(0, 9));
                3:       c = 8'h20;
                default: c = 8'($urandom);
            endcase
            send(c, 1'($urandom_range(0, 1)));
            idle_cycles($urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
